// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between the instruction and
// data ports of two cores, with data-over-instruction priority and a watchdog abort.
module mem_arbiter_core #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         iREN,
  input  logic         dREN,
  input  logic         dWEN,
  input  logic         sel,
  input  logic         gdata,
  input  logic         resp,
  input  logic         cap,
  input  logic [W-1:0] cap_data,
  output logic         active,
  output logic         iwait,
  output logic         dwait,
  output logic [W-1:0] iload,
  output logic [W-1:0] dload
);
  assign active = iREN | dREN | dWEN;
  assign iwait  = iREN & ~(resp & sel & ~gdata);
  assign dwait  = (dREN | dWEN) & ~(resp & sel & gdata);

  // Load registers only move when this core's granted port captures a response.
  always_ff @(posedge CLK) begin
    if (RST) begin
      iload <= '0;
      dload <= '0;
    end else if (cap & sel) begin
      if (gdata) dload <= cap_data;
      else       iload <= cap_data;
    end
  end
endmodule

module mem_arbiter #(
  parameter int          TIMEOUT = 255,
  parameter logic [31:0] ERRWORD = 32'hBAD1BAD1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0][31:0] iload,
  output logic [1:0]       iwait,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0][31:0] dload,
  output logic [1:0]       dwait,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic             ram_ack,
  output logic             err
);
  localparam int NCORE = 2;
  localparam int W = 32;
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic             rr, gcore, gdata, gwr;
  logic [9:0]       cnt, cnt_nxt;
  logic [NCORE-1:0] active;
  logic             pick, dsel, tmo_hit, cap, resp;
  logic [W-1:0]     cap_data;

  always_comb begin
    pick     = active[rr] ? rr : ~rr;
    dsel     = dREN[pick] | dWEN[pick];
    cnt_nxt  = cnt + 10'd1;
    tmo_hit  = (cnt_nxt == TMO);
    resp     = (state == RESP);
    // Writes capture nothing on ack; an abort always loads the error word.
    cap      = (state == ACCESS) & ((ram_ack & ~gwr) | (tmo_hit & ~ram_ack));
    cap_data = ram_ack ? ramload : ERRWORD;
  end

  for (genvar c = 0; c < NCORE; c++) begin : g_core
    mem_arbiter_core #(.W(W)) u_core (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN[c]),
      .dREN     (dREN[c]),
      .dWEN     (dWEN[c]),
      .sel      (gcore == 1'(c)),
      .gdata    (gdata),
      .resp     (resp),
      .cap      (cap),
      .cap_data (cap_data),
      .active   (active[c]),
      .iwait    (iwait[c]),
      .dwait    (dwait[c]),
      .iload    (iload[c]),
      .dload    (dload[c])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      rr       <= 1'b0;
      cnt      <= '0;
      gcore    <= 1'b0;
      gdata    <= 1'b0;
      gwr      <= 1'b0;
      ramREN   <= 1'b0;
      ramWEN   <= 1'b0;
      ramaddr  <= '0;
      ramstore <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (|active) begin
          gcore    <= pick;
          gdata    <= dsel;
          gwr      <= dWEN[pick];
          ramaddr  <= dsel ? daddr[pick] : iaddr[pick];
          ramstore <= dstore[pick];
          ramREN   <= ~dWEN[pick];
          ramWEN   <= dWEN[pick];
          cnt      <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt_nxt;
          // An ack in the final watchdog cycle still counts as success.
          if (ram_ack || tmo_hit) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            err    <= ~ram_ack;
            state  <= RESP;
          end
        end
        RESP: begin
          rr    <= ~gcore;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a RAM responder, four requesters
// and a monitor that checks grants, RAM outputs, waits and load data.
module tb_mem_arbiter;
  localparam int          T    = 4;
  localparam logic [31:0] ERRW = 32'hBAD1BAD1;

  logic             CLK = 1'b0, RST = 1'b1;
  logic [1:0]       iREN, dREN, dWEN, iwait, dwait;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload;
  logic             ramREN, ramWEN, ram_ack, err;
  logic [31:0]      ramaddr, ramstore, ramload;

  always #5 CLK = ~CLK;

  mem_arbiter #(.TIMEOUT(T), .ERRWORD(ERRW)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ack(ram_ack), .err(err)
  );

  // Requester r: core r/2, r odd = data port, r even = instruction port.
  typedef struct { int r; bit wr; logic [31:0] data; } exp_t;
  exp_t        expq[$];
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] ram_mem [logic [31:0]];
  int          fixed_dly = -1;
  int          tmo_cnt = 0;
  int          checks = 0, errors = 0;
  bit          busy [4];
  bit          done_f [4];
  int          n;

  // Addresses with bit 12 set are never acknowledged by the RAM.
  function automatic logic [31:0] init_word(logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : (~a ^ 32'h5A5A0000);
  endfunction
  function automatic bit req_of(int r);
    return (r % 2 == 1) ? (dREN[r/2] | dWEN[r/2]) : iREN[r/2];
  endfunction
  function automatic bit wait_of(int r);
    return (r % 2 == 1) ? dwait[r/2] : iwait[r/2];
  endfunction
  function automatic logic [31:0] load_of(int r);
    return (r % 2 == 1) ? dload[r/2] : iload[r/2];
  endfunction
  function automatic bit any_busy();
    return busy[0] | busy[1] | busy[2] | busy[3];
  endfunction
  function automatic logic [31:0] rnd_addr(int r);
    logic [31:0] base = (r % 2 == 1) ? 32'h20000000 : 32'h40000000;
    logic [31:0] tm = ($urandom_range(0, 7) == 0) ? 32'h1000 : 32'h0;
    return base + 32'(r / 2) * 32'h01000000 + 32'($urandom_range(0, 7)) * 4 + tm;
  endfunction

  // ---------------- RAM responder ----------------
  initial begin
    int k, dly;
    bit rbusy;
    k = 0; dly = 0; rbusy = 0;
    ram_ack = 1'b0; ramload = '0;
    forever begin
      @(posedge CLK); #1;
      ram_ack = 1'b0;
      ramload = $urandom;
      if (!RST && (ramREN | ramWEN)) begin
        if (!rbusy) begin
          rbusy = 1; k = 0;
          dly = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 3));
        end
        if (!ramaddr[12] && k == dly) begin
          ram_ack = 1'b1;
          if (ramWEN) ram_mem[ramaddr] = ramstore;
          else ramload = ram_mem.exists(ramaddr) ? ram_mem[ramaddr] : init_word(ramaddr);
        end
        k++;
      end else begin
        rbusy = 0;
        if ($urandom_range(0, 3) == 0) ram_ack = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  bit              prev_acc = 0, prev_resp = 0, prev_rst = 1, prev_ack = 0, prev_idle = 0;
  bit              rr_m = 0, acc, resp, found, exit_exp, ec, ed, ewr, expw, s_any;
  bit [1:0]        s_i, s_d, s_w, act;
  logic [1:0][31:0] s_iaddr, s_daddr, s_dstore;
  logic [31:0]     l_prev [4];
  logic [31:0]     ea, g_addr = '0, g_st = '0;
  int              g_r = 0, er, acc_len = 0, tmo_seen = 0;
  bit              g_wr = 0;
  exp_t            e;

  task automatic chk(bit ok, string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      acc  = ramREN | ramWEN;
      resp = 0;
      if (RST) begin
        prev_rst = 1; prev_acc = 0; prev_resp = 0; prev_idle = 0; rr_m = 0;
      end else begin
        chk(tmo_cnt == tmo_seen, "bounded_wait", tmo_cnt, tmo_seen);
        tmo_seen = tmo_cnt;
        if (prev_rst) begin
          chk(!acc, "rst_ram_en", 32'(acc), 0);
          chk(ramaddr == 0, "rst_ramaddr", ramaddr, 0);
          chk(ramstore == 0, "rst_ramstore", ramstore, 0);
          for (int r = 0; r < 4; r++) chk(load_of(r) == 0, "rst_load", load_of(r), 0);
        end
        if (prev_acc) begin
          exit_exp = prev_ack || (acc_len >= T);
          chk(acc == !exit_exp, "access_exit", 32'(acc), 32'(!exit_exp));
        end
        if (prev_idle) begin
          chk(acc == s_any, "grant_start", 32'(acc), 32'(s_any));
          if (acc && s_any) begin
            act = s_i | s_d | s_w;
            ec  = act[rr_m] ? rr_m : !rr_m;
            ed  = s_d[ec] | s_w[ec];
            ewr = s_w[ec];
            er  = int'(ec) * 2 + int'(ed);
            ea  = ed ? s_daddr[ec] : s_iaddr[ec];
            chk(ramaddr == ea, "grant_addr", ramaddr, ea);
            chk(ramWEN == ewr && ramREN == !ewr, "grant_rw", {30'd0, ramWEN, ramREN}, {30'd0, ewr, !ewr});
            if (ewr) chk(ramstore == s_dstore[ec], "grant_store", ramstore, s_dstore[ec]);
            g_r = er; g_wr = ewr; g_addr = ea; g_st = s_dstore[ec]; acc_len = 1;
          end
        end else if (!prev_acc) begin
          chk(!acc, "grant_outside_idle", 32'(acc), 0);
        end
        if (prev_acc && acc) begin
          acc_len++;
          chk(ramaddr == g_addr, "hold_addr", ramaddr, g_addr);
          chk(ramWEN == g_wr, "hold_wen", 32'(ramWEN), 32'(g_wr));
          if (g_wr) chk(ramstore == g_st, "hold_store", ramstore, g_st);
        end
        resp = prev_acc && !acc;
        chk(err == (resp && !prev_ack), "err_pulse", 32'(err), 32'(resp && !prev_ack));
        for (int r = 0; r < 4; r++) begin
          expw = req_of(r) && !(resp && r == g_r);
          chk(wait_of(r) == expw, "wait", 32'(wait_of(r)), 32'(expw));
          if (resp && r == g_r) begin
            if (req_of(r)) begin
              found = 0;
              for (int i = 0; i < expq.size(); i++)
                if (!found && expq[i].r == r) begin
                  e = expq[i]; expq.delete(i); found = 1;
                end
              chk(found, "scoreboard_entry", 32'(found), 1);
              if (found && !e.wr) chk(load_of(r) == e.data, "load_data", load_of(r), e.data);
            end
          end else if (!prev_rst) begin
            chk(load_of(r) == l_prev[r], "load_hold", load_of(r), l_prev[r]);
          end
        end
        if (resp) rr_m = (g_r / 2 == 0);
        s_i = iREN; s_d = dREN; s_w = dWEN;
        s_iaddr = iaddr; s_daddr = daddr; s_dstore = dstore;
        s_any = |(iREN | dREN | dWEN);
        prev_idle = !acc && !resp;
        prev_acc = acc; prev_resp = resp; prev_rst = 0;
      end
      prev_ack = ram_ack;
      for (int r = 0; r < 4; r++) l_prev[r] = load_of(r);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(int r, bit wr, logic [31:0] a, logic [31:0] d);
    int c = r / 2;
    exp_t x;
    x.r = r; x.wr = wr;
    if (r % 2 == 0) begin
      iREN[c] = 1'b1; iaddr[c] = a;
    end else begin
      dWEN[c] = wr;
      dREN[c] = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      daddr[c] = a; dstore[c] = d;
    end
    if (a[12]) x.data = ERRW;
    else x.data = exp_mem.exists(a) ? exp_mem[a] : init_word(a);
    if (wr && !a[12]) exp_mem[a] = d;
    expq.push_back(x);
    busy[r] = 1;
  endtask

  task automatic drop(int r);
    if (r % 2 == 0) iREN[r/2] = 1'b0;
    else begin dREN[r/2] = 1'b0; dWEN[r/2] = 1'b0; end
  endtask

  task automatic cyc();
    @(negedge CLK);
    for (int r = 0; r < 4; r++) if (busy[r] && req_of(r) && !wait_of(r)) done_f[r] = 1;
    @(posedge CLK); #1;
    for (int r = 0; r < 4; r++) if (done_f[r]) begin drop(r); busy[r] = 0; done_f[r] = 0; end
  endtask

  task automatic drain(int budget);
    int k = 0;
    while (any_busy() && k < budget) begin cyc(); k++; end
    if (any_busy()) begin
      tmo_cnt++;
      for (int r = 0; r < 4; r++) begin drop(r); busy[r] = 0; end
    end
  endtask

  initial begin
    iREN = '0; dREN = '0; dWEN = '0; iaddr = '0; daddr = '0; dstore = '0;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Single data read with a 1-cycle ack.
    fixed_dly = 0;
    issue(1, 0, 32'h100, 32'h0);
    drain(20);
    // Write and instruction fetch on core0 at once: write goes first.
    fixed_dly = -1;
    issue(1, 1, 32'h200, 32'h55);
    issue(0, 0, 32'h40000040, 32'h0);
    drain(40);
    // Both cores streaming instruction fetches.
    for (int k = 0; k < 30; k++) begin
      for (int c = 0; c < 2; c++) if (!busy[2*c]) issue(2*c, 0, rnd_addr(2*c) & ~32'h1000, 32'h0);
      cyc();
    end
    drain(40);
    // Watchdog abort, then a normal access.
    issue(3, 0, 32'h21001000, 32'h0);
    drain(20);
    issue(3, 0, 32'h21000008, 32'h0);
    drain(20);
    // Reset in the second ACCESS cycle; the request is re-arbitrated afterwards.
    issue(0, 0, 32'h40001000, 32'h0);
    n = 0;
    do begin cyc(); n++; end while (!ramREN && n < 10);
    if (!ramREN) tmo_cnt++;
    cyc();
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    drain(30);
    // Data read dropped mid-ACCESS with its address changed.
    fixed_dly = 2;
    dREN[1] = 1'b1; daddr[1] = 32'h21000010;
    n = 0;
    do begin cyc(); n++; end while (!ramREN && n < 10);
    if (!ramREN) tmo_cnt++;
    dREN[1] = 1'b0; daddr[1] = $urandom;
    issue(0, 0, 32'h40000044, 32'h0);
    drain(30);
    fixed_dly = -1;
    // Random traffic on all four requesters.
    for (int k = 0; k < 600; k++) begin
      for (int r = 0; r < 4; r++)
        if (!busy[r] && $urandom_range(0, 9) < 6)
          issue(r, (r % 2 == 1) && ($urandom_range(0, 1) == 1), rnd_addr(r), $urandom);
      cyc();
    end
    drain(300);
    if (expq.size() != 0) tmo_cnt++;
    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
